// File: rtl/instr_load_seq.sv
// Program loader and instruction sequencer.
// LOAD mode packs switch bytes MSB-first into instruction words and writes
// them into a small buffer. RUN mode replays the buffer to the datapath,
// one word per button press (step) or back-to-back (free).
//
// Handshake: instr_out/instr_valid are registered. While instr_valid=1 they
// are held stable until a cycle with instr_ready=1, and a word is transferred
// exactly on an enabled clock edge where instr_valid=1 and instr_ready=1.
// Dropping run_mode takes priority over a coincident ready, and pc is not
// advanced in that case.

module instr_load_seq_deb #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic raw,
    output logic press
);
    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [DCW-1:0] LIM = DCW'(DEB_CYCLES - 1);

    logic           s1, s2, lvl;
    logic [DCW-1:0] cnt;

    // Synchronise, then accept a new level only after it has persisted;
    // a rising acceptance emits a single press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else if (en) begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            if (s2 != lvl) begin
                if (cnt == LIM) begin
                    lvl   <= s2;
                    cnt   <= '0;
                    press <= s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module instr_load_seq #(
    parameter int DATA_W     = 16,
    parameter int IN_W       = 8,
    parameter int DEPTH      = 16,
    parameter int DEB_CYCLES = 4,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic [IN_W-1:0]   input_instruction,
    input  logic              button,
    input  logic              pc_butt,
    input  logic              run_mode,
    input  logic              free_run,
    input  logic              clear,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic [AW:0]       pc,
    output logic [CW-1:0]     load_count,
    output logic [DATA_W-1:0] led_ins,
    output logic              full,
    output logic              done,
    output logic [1:0]        state_dbg
);
    localparam int PW  = AW + 1;
    localparam int BPW = DATA_W / IN_W;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(BPW - 1);
    localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_IDLE  = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [BIW-1:0]    byte_idx;
    logic [DATA_W-1:0] asm_q, asm_new, led_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     pc_nxt, lc_ext;
    logic              btn_press, step_press;
    logic              capture, word_done, clr, enter_run;

    instr_load_seq_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
        .clk(clk), .reset(reset), .en(clk_enable), .raw(button), .press(btn_press)
    );

    instr_load_seq_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .reset(reset), .en(clk_enable), .raw(pc_butt), .press(step_press)
    );

    assign asm_new   = (asm_q << IN_W) | DATA_W'(input_instruction);
    assign lc_ext    = PW'(load_count);
    assign full      = (load_count == DEPTH_C);
    assign done      = (state == S_DONE);
    assign led_ins   = (state == S_LOAD) ? led_q : instr_out;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          state <= S_LOAD;
        else if (clk_enable) state <= state_nxt;
    end

    // Next state, next pc and load-side strobes. Mode change beats a byte press.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        word_done = 1'b0;
        clr       = 1'b0;
        enter_run = 1'b0;
        case (state)
            S_LOAD: begin
                if (run_mode) begin
                    enter_run = 1'b1;
                    pc_nxt    = '0;
                    state_nxt = (load_count == '0) ? S_DONE : S_IDLE;
                end else if (clear) begin
                    clr    = 1'b1;
                    pc_nxt = '0;
                end else if (btn_press && !full) begin
                    capture   = 1'b1;
                    word_done = (byte_idx == LAST_BYTE);
                end
            end
            S_IDLE: begin
                if (!run_mode)                  state_nxt = S_LOAD;
                else if (free_run || step_press) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (!run_mode) begin
                    state_nxt = S_LOAD;
                end else if (instr_ready) begin
                    pc_nxt = pc + PW'(1);
                    if (pc_nxt == lc_ext) state_nxt = S_DONE;
                    else if (!free_run)   state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (!run_mode) state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Datapath: pc, issue registers, byte assembly and word count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            load_count  <= '0;
            byte_idx    <= '0;
            asm_q       <= '0;
            led_q       <= '0;
        end else if (clk_enable) begin
            pc          <= pc_nxt;
            instr_valid <= (state_nxt == S_ISSUE);
            if (state_nxt == S_ISSUE) instr_out <= mem[pc_nxt[AW-1:0]];
            if (enter_run || clr) begin
                asm_q    <= '0;
                byte_idx <= '0;
                led_q    <= '0;
            end
            if (clr) load_count <= '0;
            if (capture) begin
                led_q <= asm_new;
                if (word_done) begin
                    asm_q      <= '0;
                    byte_idx   <= '0;
                    load_count <= load_count + 1'b1;
                end else begin
                    asm_q    <= asm_new;
                    byte_idx <= byte_idx + 1'b1;
                end
            end
        end
    end

    // Instruction buffer; contents survive reset.
    always_ff @(posedge clk) begin
        if (clk_enable && capture && word_done) mem[load_count[AW-1:0]] <= asm_new;
    end
endmodule

// File: tb/tb_instr_load_seq.sv
// Directed bench for instr_load_seq: loading, debounce, full, step/free
// issue, async reset and clock-enable hold.
module tb_instr_load_seq;
  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [7:0]  input_instruction;
  logic        button;
  logic        pc_butt;
  logic        run_mode;
  logic        free_run;
  logic        clear;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [2:0]  pc;
  logic [2:0]  load_count;
  logic [15:0] led_ins;
  logic        full;
  logic        done;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [15:0] words [4];

  instr_load_seq #(.DATA_W(16), .IN_W(8), .DEPTH(4), .DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .input_instruction(input_instruction), .button(button), .pc_butt(pc_butt),
    .run_mode(run_mode), .free_run(free_run), .clear(clear),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_valid(instr_valid),
    .pc(pc), .load_count(load_count), .led_ins(led_ins), .full(full),
    .done(done), .state_dbg(state_dbg)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_byte(input logic [7:0] b);
    input_instruction = b;
    button = 1'b1;
    tick(8);
    button = 1'b0;
    tick(8);
  endtask

  task automatic press_step();
    pc_butt = 1'b1;
    tick(8);
    pc_butt = 1'b0;
  endtask

  initial begin
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
    reset = 1'b0; clk_enable = 1'b1; input_instruction = '0; button = 1'b0;
    pc_butt = 1'b0; run_mode = 1'b0; free_run = 1'b0; clear = 1'b0; instr_ready = 1'b0;
    tick(3);
    check("rst_out", instr_out, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_lc", load_count, 0);
    check("rst_led", led_ins, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b1;
    tick(2);

    // two bytes make one word
    press_byte(8'h12);
    check("led_byte1", led_ins, 16'h0012);
    check("lc_byte1", load_count, 0);
    press_byte(8'h34);
    check("led_word1", led_ins, 16'h1234);
    check("lc_word1", load_count, 1);

    // short glitch is filtered, clean press captures once
    input_instruction = 8'hAB;
    button = 1'b1; tick(2); button = 1'b0; tick(8);
    check("glitch_led", led_ins, 16'h1234);
    check("glitch_lc", load_count, 1);
    button = 1'b1; tick(10); button = 1'b0; tick(8);
    check("clean_led", led_ins, 16'h00AB);
    check("clean_lc", load_count, 1);

    // clear
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clr_lc", load_count, 0);
    check("clr_led", led_ins, 0);
    check("clr_full", full, 0);

    // load four words, with a disabled-clock window mid-word
    press_byte(8'h12); press_byte(8'h34); press_byte(8'h56);
    check("mid_led", led_ins, 16'h0056);
    clk_enable = 1'b0; input_instruction = 8'h77; button = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("hold_led", led_ins, 16'h0056);
      check("hold_lc", load_count, 1);
    end
    button = 1'b0; clk_enable = 1'b1; tick(8);
    check("hold_after_led", led_ins, 16'h0056);
    press_byte(8'h78);
    check("w2_led", led_ins, 16'h5678);
    check("w2_lc", load_count, 2);
    press_byte(8'h9A); press_byte(8'hBC); press_byte(8'hDE); press_byte(8'hF0);
    check("w4_led", led_ins, 16'hDEF0);
    check("w4_lc", load_count, 4);
    check("w4_full", full, 1);
    press_byte(8'hFF);
    check("sat_lc", load_count, 4);
    check("sat_led", led_ins, 16'hDEF0);
    check("sat_full", full, 1);

    // RUN step mode, ready held low
    run_mode = 1'b1; tick(1);
    check("run_state", state_dbg, 1);
    check("run_pc", pc, 0);
    check("run_valid", instr_valid, 0);
    press_step();
    for (int i = 0; i < 3; i++) begin
      check("step_valid", instr_valid, 1);
      check("step_out", instr_out, 16'h1234);
      check("step_led", led_ins, 16'h1234);
      tick(1);
    end
    instr_ready = 1'b1; tick(1); instr_ready = 1'b0;
    check("hs_pc", pc, 1);
    check("hs_valid", instr_valid, 0);
    check("hs_state", state_dbg, 1);
    tick(6);
    press_byte(8'h55);
    check("run_btn_lc", load_count, 4);
    check("run_btn_state", state_dbg, 1);

    // back to LOAD holds pc, then free run from pc=0
    run_mode = 1'b0; tick(1);
    check("ld_state", state_dbg, 0);
    check("ld_pc", pc, 1);
    free_run = 1'b1; instr_ready = 1'b1; run_mode = 1'b1;
    tick(1);
    check("free_idle_pc", pc, 0);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("free_valid", instr_valid, 1);
      check("free_out", instr_out, {16'h0, words[i]});
      check("free_pc", pc, i);
      tick(1);
    end
    check("free_done", done, 1);
    check("free_end_pc", pc, 4);
    check("free_end_valid", instr_valid, 0);
    check("free_end_state", state_dbg, 3);

    // async reset in the middle of an issue
    run_mode = 1'b0; instr_ready = 1'b0; tick(1);
    run_mode = 1'b1; tick(2);
    check("pre_rst_valid", instr_valid, 1);
    #1 reset = 1'b0; #1;
    check("arst_out", instr_out, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_pc", pc, 0);
    check("arst_lc", load_count, 0);
    check("arst_led", led_ins, 0);
    check("arst_full", full, 0);
    check("arst_state", state_dbg, 0);
    tick(2);
    reset = 1'b1;
    // empty buffer goes straight to DONE
    tick(2);
    check("empty_done", done, 1);
    check("empty_state", state_dbg, 3);
    check("empty_valid", instr_valid, 0);
    run_mode = 1'b0; tick(1);
    check("empty_exit", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_load_seq.md
Name: instr_load_seq

Overview:
- Parametrised program loader and instruction sequencer; successor to the switch-and-button instruction entry on the 16-bit processor top.
- LOAD mode: assembles IN_W-bit switch bytes into DATA_W-bit words, written into a DEPTH-entry instruction buffer.
- RUN mode: issues stored words to the datapath over a valid/ready handshake, either single-step (pc_butt) or free-running.
- Sits between the board switches/buttons and the datapath instruction input.

Parameters:
DATA_W, 16, instruction word width; must be a multiple of IN_W.
IN_W, 8, switch byte width.
DEPTH, 16, instruction buffer entries; AW = clog2(DEPTH), CW = clog2(DEPTH+1).
DEB_CYCLES, 4, enabled cycles a synchronised button level must be stable to be accepted.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
clk_enable  input  1  global tick; all state advances only on clk edges with clk_enable=1
input_instruction  input  IN_W  switch byte
button  input  1  raw load-byte button
pc_butt  input  1  raw step button
run_mode  input  1  0=LOAD, 1=RUN
free_run  input  1  RUN sub-mode: 0=step, 1=free
clear  input  1  synchronous buffer clear (sampled on enabled cycles)
instr_ready  input  1  datapath accepts instr_out
instr_out  output  DATA_W  issued instruction
instr_valid  output  1  instr_out valid
pc  output  AW+1  next index to issue
load_count  output  CW  words stored
led_ins  output  DATA_W  word under assembly (LOAD) / instr_out (RUN)
full  output  1  load_count==DEPTH
done  output  1  RUN reached pc==load_count

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=LOAD, byte index 0, assembly register 0, debouncers cleared. Buffer contents are not reset. The reset dominates clk_enable.
- "Cycle" below means an enabled cycle (clk_enable=1). When clk_enable=0, all state holds, including debounce counters.
- Debounce per button:
  - 2-FF synchroniser, then a counter.
  - The debounced level changes only after the synchronised level differs from it for DEB_CYCLES consecutive cycles.
  - press = 1-cycle pulse on a debounced 0->1 transition.
  - A glitch shorter than DEB_CYCLES produces no press.
  - A press is delivered between DEB_CYCLES+1 and DEB_CYCLES+3 cycles after the raw edge.
- BPW = DATA_W/IN_W. Byte assembly is MSB-first. On a button press in LOAD with full=0:
  - asm = {asm[DATA_W-IN_W-1:0], input_instruction}; byte index increments.
  - On the BPW-th byte: write the completed word to mem[load_count[AW-1:0]], load_count+1, byte index and asm reset to 0.
  - led_ins shows asm after each capture, and the completed word on the cycle after the write.
- full=1: further presses are ignored. No wrap-around; load_count saturates at DEPTH.
- clear=1 in LOAD: load_count, byte index, asm and pc go to 0 next cycle; full and done go to 0. clear is ignored in RUN.
- FSM states LOAD, IDLE, ISSUE, DONE:
  - LOAD -> IDLE when run_mode=1. The partial asm is discarded and pc=0. If load_count==0, go directly to DONE.
  - IDLE -> ISSUE on a pc_butt press (step) or immediately (free). The state entered presents instr_out=mem[pc], instr_valid=1.
  - ISSUE: instr_out and instr_valid are held stable until instr_ready=1. On the handshake cycle, pc+1.
    - If new pc==load_count: -> DONE, instr_valid=0.
    - Else in free mode: stay in ISSUE with the next word; back-to-back issue at one word per cycle when ready=1.
    - Else in step mode: -> IDLE, instr_valid=0.
  - DONE: done=1, instr_valid=0. Leaves only on run_mode=0.
  - Any RUN state -> LOAD when run_mode=0. instr_valid drops next cycle and pc is held. Loading resumes appending at load_count.
- pc_butt presses in LOAD, and button presses in RUN, are discarded.
- A simultaneous button press and run_mode 0->1 on the same cycle: the mode change wins and the byte is discarded.

Test Plan:
- Setup: DATA_W=16, IN_W=8, DEPTH=4, DEB_CYCLES=4, clk_enable tied 1. Press bytes 0x12, 0x34 -> led_ins 0x0012 then 0x1234; load_count=1; mem[0]=0x1234.
- 2-cycle button glitch, then a clean 10-cycle press of 0xAB -> exactly one capture; byte index 1.
- Load 4 words (0x1234, 0x5678, 0x9ABC, 0xDEF0) -> full=1. A 5th press of byte 0xFF leaves load_count=4 and the contents unchanged.
- RUN, step, instr_ready=0: a pc_butt press gives instr_valid=1, instr_out=0x1234, stable for 3 cycles. Raise ready -> pc=1, valid=0, state IDLE.
- RUN, free, ready=1 -> valid on 4 consecutive cycles with 0x1234, 0x5678, 0x9ABC, 0xDEF0; then done=1, pc=4.
- Reset pulse mid-ISSUE -> all outputs 0 immediately. Separately, hold clk_enable=0 for 5 cycles mid-load -> no state change.
